pc_sequencer: RTL and testbench

- Program-counter and control-flow stage that sits directly upstream of the call stack.
- Holds the PC and selects the next PC from sequential, jump, branch, call and return sources.
- Generates the call stack's addr/push/en strobes and consumes its combinational top-of-stack output as the return target.
- Tracks stack depth, so it faults cleanly instead of letting the stack pointer wrap, and unwinds the stack on reset.

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_depth_tracker.sv | 27 ++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared op encodings, FSM states and depth limits
package pc_sequencer_pkg;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    localparam int STACK_PTR_WIDTH_DFLT = 6;
    localparam int MAX_DEPTH = (1 << STACK_PTR_WIDTH_DFLT) - 1;

    typedef enum logic [1:0] {
        ST_UNWIND,
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/pc_sequencer_depth_tracker.sv
// depth_tracker: saturating up/down occupancy counter that deliberately ignores reset
module depth_tracker #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_zero
);

    logic [W-1:0] count_q = '0;

    // Count follows the real stack pointer, so it survives reset and saturates at both ends
    always_ff @(posedge clk) begin
        if (inc && !at_max)
            count_q <= count_q + W'(1);
        else if (dec && !at_zero)
            count_q <= count_q - W'(1);
    end

    assign count   = count_q;
    assign at_max  = count_q == '1;
    assign at_zero = count_q == '0;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and call-stack control with depth tracking and reset unwind
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_ADDR_SIZE = 10,
    parameter int STACK_PTR_WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic [2:0]                       op,
    input  logic                             zero,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] target,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] ret_addr,
    output logic [INSTRUCTION_ADDR_SIZE-1:0] pc,
    output logic [INSTRUCTION_ADDR_SIZE-1:0] cs_addr,
    output logic                             cs_push,
    output logic                             cs_en,
    output logic [STACK_PTR_WIDTH-1:0]       depth,
    output logic                             halted,
    output logic                             fault
);

    state_t                           state_q, state_d;
    logic [INSTRUCTION_ADDR_SIZE-1:0] pc_q, pc_d, pc_inc;
    logic                             fault_q, fault_d, halted_q, halted_d;
    logic                             at_max, at_zero;

    assign pc_inc = pc_q + INSTRUCTION_ADDR_SIZE'(1);

    depth_tracker #(.W(STACK_PTR_WIDTH)) u_depth (
        .clk     (clk),
        .inc     (cs_en && cs_push),
        .dec     (cs_en && !cs_push),
        .count   (depth),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    // State, pc and sticky flags; next values come from the control process
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        pc_q     <= pc_d;
        fault_q  <= fault_d;
        halted_q <= halted_d;
    end

    // Next-state, next-pc and stack strobe decode; strobes stay low under reset
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fault_d  = fault_q;
        halted_d = halted_q;
        cs_en    = 1'b0;
        cs_push  = 1'b0;
        if (rst) begin
            state_d  = ST_UNWIND;
            pc_d     = '0;
            fault_d  = 1'b0;
            halted_d = 1'b0;
        end else if (state_q == ST_UNWIND) begin
            cs_en   = !at_zero;
            state_d = at_zero ? ST_RUN : ST_UNWIND;
            pc_d    = '0;
        end else if (state_q == ST_RUN && !stall) begin
            case (op)
                OP_JMP:  pc_d = target;
                OP_BRZ:  pc_d = zero ? target : pc_inc;
                OP_CALL: begin
                    cs_en   = !at_max;
                    cs_push = !at_max;
                    pc_d    = at_max ? pc_q : target;
                    fault_d = at_max;
                    state_d = at_max ? ST_FAULT : ST_RUN;
                end
                OP_RET: begin
                    cs_en   = !at_zero;
                    pc_d    = at_zero ? pc_q : ret_addr;
                    fault_d = at_zero;
                    state_d = at_zero ? ST_FAULT : ST_RUN;
                end
                OP_HALT: begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    assign pc      = pc_q;
    assign cs_addr = pc_inc;
    assign fault   = fault_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench with a behavioural call-stack model
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] op = 3'd0;
    logic       zero = 1'b0;
    logic [9:0] target = '0;
    logic [9:0] ret_addr = '0;
    logic [9:0] pc, cs_addr;
    logic       cs_push, cs_en, halted, fault;
    logic [5:0] depth;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] pc;
        logic [5:0] depth;
        logic       fault;
        logic       halted;
    } exp_t;

    exp_t exp_q[$];

    int         m_state = 0;
    logic [9:0] m_pc = '0;
    int         m_depth = 0;
    logic       m_fault = 1'b0;
    logic       m_halted = 1'b0;
    logic [9:0] m_stk[0:63];

    pc_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .op       (op),
        .zero     (zero),
        .target   (target),
        .ret_addr (ret_addr),
        .pc       (pc),
        .cs_addr  (cs_addr),
        .cs_push  (cs_push),
        .cs_en    (cs_en),
        .depth    (depth),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // model states: 0 unwind, 1 run, 2 halted, 3 fault
    task automatic step(input logic r, input logic s, input logic [2:0] o, input logic z, input logic [9:0] t);
        logic       e_en, e_push;
        logic [9:0] e_addr;
        exp_t       e, g;
        @(negedge clk);
        rst = r; stall = s; op = o; zero = z; target = t;
        ret_addr = m_stk[m_depth];
        e_en = 1'b0; e_push = 1'b0; e_addr = m_pc + 10'd1;
        if (r) begin
            m_state = 0; m_pc = '0; m_fault = 1'b0; m_halted = 1'b0;
        end else if (m_state == 0) begin
            if (m_depth > 0) begin
                e_en = 1'b1; m_depth--;
            end else begin
                m_state = 1; m_pc = '0;
            end
        end else if (m_state == 1 && !s) begin
            if (o == 3'd1) m_pc = t;
            else if (o == 3'd2) m_pc = z ? t : m_pc + 10'd1;
            else if (o == 3'd3) begin
                if (m_depth == 63) begin m_fault = 1'b1; m_state = 3; end
                else begin
                    e_en = 1'b1; e_push = 1'b1; m_depth++;
                    m_stk[m_depth] = m_pc + 10'd1; m_pc = t;
                end
            end else if (o == 3'd4) begin
                if (m_depth == 0) begin m_fault = 1'b1; m_state = 3; end
                else begin
                    e_en = 1'b1; m_pc = m_stk[m_depth]; m_depth--;
                end
            end else if (o == 3'd5) begin
                m_halted = 1'b1; m_state = 2;
            end else m_pc = m_pc + 10'd1;
        end
        #1;
        chk("cs_en", 32'(cs_en), 32'(e_en));
        if (e_en) chk("cs_push", 32'(cs_push), 32'(e_push));
        if (e_en && e_push) chk("cs_addr", 32'(cs_addr), 32'(e_addr));
        e.pc = m_pc; e.depth = 6'(m_depth); e.fault = m_fault; e.halted = m_halted;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) chk("queue", 32'(0), 32'(1));
        else begin
            g = exp_q.pop_front();
            chk("pc", 32'(pc), 32'(g.pc));
            chk("depth", 32'(depth), 32'(g.depth));
            chk("fault", 32'(fault), 32'(g.fault));
            chk("halted", 32'(halted), 32'(g.halted));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_stk[i] = '0;
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 10'h005);
        step(0, 0, 3, 0, 10'h040);
        chk("call_pc", 32'(pc), 32'h40);
        step(0, 0, 0, 0, 0);
        chk("seq_pc", 32'(pc), 32'h41);
        step(0, 0, 4, 0, 0);
        chk("ret_pc", 32'(pc), 32'h6);
        step(0, 0, 4, 0, 0);
        chk("underflow_fault", 32'(fault), 32'(1));
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 10'h123);
        step(0, 0, 3, 0, 10'h200);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 63; i++) step(0, 0, 3, 0, 10'(i * 7));
        chk("max_depth", 32'(depth), 32'(pc_sequencer_pkg::MAX_DEPTH));
        step(0, 0, 3, 0, 10'h3ff);
        chk("overflow_fault", 32'(fault), 32'(1));
        step(1, 0, 0, 0, 0);
        repeat (64) step(0, 1, 0, 0, 0);
        step(0, 0, 3, 0, 10'h010);
        step(0, 0, 3, 0, 10'h020);
        step(0, 0, 3, 0, 10'h030);
        step(1, 1, 3, 0, 10'h050);
        repeat (4) step(0, 1, 3, 0, 10'h050);
        chk("unwound", 32'(depth), 32'(0));
        repeat (4) step(0, 1, 3, 0, 10'h050);
        step(0, 0, 3, 0, 10'h050);
        step(0, 0, 4, 0, 0);
        step(0, 0, 1, 0, 10'h007);
        step(0, 0, 2, 0, 10'h010);
        step(0, 0, 2, 1, 10'h010);
        chk("brz_taken", 32'(pc), 32'h10);
        step(0, 0, 1, 0, 10'h3ff);
        step(0, 0, 0, 0, 0);
        chk("wrap", 32'(pc), 32'h0);
        step(0, 0, 6, 0, 0);
        step(0, 0, 7, 0, 0);
        step(0, 0, 5, 0, 0);
        step(0, 0, 3, 0, 10'h111);
        step(0, 0, 1, 0, 10'h222);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 4 + ($urandom_range(0, 9) == 0 ? 3 : 0))),
                 1'($urandom_range(0, 1)), 10'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
